keypad_debouncer: RTL

Debounce and decode stage placed directly downstream of the keypad row scanner. It captures the scanner's `{row, column}` code on the scanner's decode strobe and qualifies the press over a configurable debounce window. Each accepted key becomes a hex digit, shifted into a two-digit history that feeds the dual seven-segment display driver. One press produces exactly one accepted digit, regardless of bounce or hold time.

---
 rtl/keypad_pkg.sv | 49 ++++
 rtl/keypad_decode.sv | 32 +++
 rtl/keypad_debouncer.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// ============================================================================
// Module      : keypad_pkg
// Description : Shared types and constants for the keypad debounce/decode
//               stage: FSM state encoding, key map and default timing.
//               Optional feature macro used by the top: KEYPAD_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package keypad_pkg;

    // Debounce/qualification FSM states
    typedef enum logic [2:0] {
        ST_IDLE       = 3'd0,
        ST_PRESS_DB   = 3'd1,
        ST_ACCEPT     = 3'd2,
        ST_HELD       = 3'd3,
        ST_RELEASE_DB = 3'd4
    } state_t;

    // Key map indexed by {row_index, col_index}; row 0 is R0, column 0 is C0
    localparam logic [3:0] c_key_map [16] = '{
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Default timing: 1 ms debounce and 250 ms repeat at 50 MHz
    localparam int unsigned c_debounce_cycles_default = 50000;
    localparam int unsigned c_repeat_cycles_default   = 12500000;

    // Position of the single set bit, MSB first (bit 3 -> 0 ... bit 0 -> 3)
    function automatic logic [1:0] onehot4_index(input logic [3:0] v);
        logic [1:0] idx;
        idx = 2'd0;
        unique case (v)
            4'b1000: idx = 2'd0;
            4'b0100: idx = 2'd1;
            4'b0010: idx = 2'd2;
            4'b0001: idx = 2'd3;
            default: idx = 2'd0;
        endcase
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keypad_decode.sv
// ============================================================================
// Module      : keypad_decode
// Description : Combinational row/column to hex digit decoder. The scanner
//               code is {R0,R1,R2,R3,C0,C1,C2,C3}; a code is valid only when
//               exactly one row bit and exactly one column bit are set.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_decode
    import keypad_pkg::*;
(
    input  logic [7:0] keypad_val,
    output logic       valid,
    output logic [3:0] digit
);

    logic [3:0] w_row;
    logic [3:0] w_col;

    assign w_row = keypad_val[7:4];
    assign w_col = keypad_val[3:0];

    // Qualify the code and look up the digit for the pressed position
    always_comb begin
        valid = $onehot(w_row) && $onehot(w_col);
        digit = c_key_map[{onehot4_index(w_row), onehot4_index(w_col)}];
    end

endmodule

`default_nettype wire

// File: rtl/keypad_debouncer.sv
// ============================================================================
// Module      : keypad_debouncer
// Description : Captures the scanner code on the decode strobe, debounces
//               press and release over DEBOUNCE_CYCLES, and shifts each
//               accepted key into a two-digit history for the display.
//               Optional feature macro: KEYPAD_REPEAT_EN (held-key repeat
//               every REPEAT_CYCLES cycles in HELD).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module keypad_debouncer
    import keypad_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = c_debounce_cycles_default,
    parameter int unsigned REPEAT_CYCLES   = c_repeat_cycles_default
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] keypad_val,
    input  logic       en,
    input  logic       button_on,
    output logic [3:0] new_digit,
    output logic [3:0] old_digit,
    output logic       digit_valid,
    output logic       key_held
);

    localparam logic [23:0] c_db_last = 24'(DEBOUNCE_CYCLES - 1);

    // Reject out-of-range configurations at elaboration time
    if (DEBOUNCE_CYCLES < 2 || DEBOUNCE_CYCLES > 32'h00FF_FFFF ||
        REPEAT_CYCLES < 1 || REPEAT_CYCLES > 32'h00FF_FFFF) begin : g_param_check
        $error("keypad_debouncer: DEBOUNCE_CYCLES or REPEAT_CYCLES out of range");
    end

    state_t      r_state;
    state_t      w_state_next;
    logic [23:0] r_cnt;
    logic [23:0] w_cnt_next;
    logic [3:0]  r_cand;
    logic [3:0]  w_cand_next;
    logic [3:0]  r_new_digit;
    logic [3:0]  r_old_digit;
    logic        r_digit_valid;
    logic        r_key_held;
    logic        w_digit_valid_next;
    logic        w_key_held_next;
    logic        w_dec_valid;
    logic [3:0]  w_dec_digit;

    keypad_decode u_decode (
        .keypad_val (keypad_val),
        .valid      (w_dec_valid),
        .digit      (w_dec_digit)
    );

`ifdef KEYPAD_REPEAT_EN
    localparam logic [23:0] c_rpt_last = 24'(REPEAT_CYCLES - 1);

    logic [23:0] r_rpt_cnt;

    // Repeat counter counts consecutive HELD cycles; zero on entry and exit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rpt_cnt <= 24'd0;
        end else if (r_state == ST_HELD && w_state_next == ST_HELD) begin
            r_rpt_cnt <= r_rpt_cnt + 24'd1;
        end else begin
            r_rpt_cnt <= 24'd0;
        end
    end
`endif

    // State, counter, candidate and registered outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state       <= ST_IDLE;
            r_cnt         <= 24'd0;
            r_cand        <= 4'd0;
            r_new_digit   <= 4'd0;
            r_old_digit   <= 4'd0;
            r_digit_valid <= 1'b0;
            r_key_held    <= 1'b0;
        end else begin
            r_state       <= w_state_next;
            r_cnt         <= w_cnt_next;
            r_cand        <= w_cand_next;
            r_digit_valid <= w_digit_valid_next;
            r_key_held    <= w_key_held_next;
            // History shifts on the same edge that raises digit_valid
            if (w_state_next == ST_ACCEPT) begin
                r_old_digit <= r_new_digit;
                r_new_digit <= r_cand;
            end
        end
    end

    // Next-state, debounce counter and candidate capture
    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_cand_next  = r_cand;
        unique case (r_state)
            ST_IDLE: begin
                if (en && w_dec_valid) begin
                    w_cand_next  = w_dec_digit;
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_PRESS_DB;
                end
            end
            ST_PRESS_DB: begin
                if (!button_on) begin
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_IDLE;
                end else if (r_cnt == c_db_last) begin
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_ACCEPT;
                end else begin
                    w_cnt_next   = r_cnt + 24'd1;
                end
            end
            ST_ACCEPT: begin
                w_cnt_next   = 24'd0;
                w_state_next = ST_HELD;
            end
            ST_HELD: begin
                if (!button_on) begin
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_RELEASE_DB;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (r_rpt_cnt == c_rpt_last) begin
                    w_state_next = ST_ACCEPT;
                end
`endif
            end
            ST_RELEASE_DB: begin
                if (button_on) begin
                    // Release bounce: back to HELD without a new digit
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_HELD;
                end else if (r_cnt == c_db_last) begin
                    w_cnt_next   = 24'd0;
                    w_state_next = ST_IDLE;
                end else begin
                    w_cnt_next   = r_cnt + 24'd1;
                end
            end
            default: begin
                w_cnt_next   = 24'd0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // Moore output decode of the upcoming state, registered above
    always_comb begin
        w_digit_valid_next = (w_state_next == ST_ACCEPT);
        w_key_held_next    = (w_state_next == ST_ACCEPT) ||
                             (w_state_next == ST_HELD)   ||
                             (w_state_next == ST_RELEASE_DB);
    end

    assign new_digit   = r_new_digit;
    assign old_digit   = r_old_digit;
    assign digit_valid = r_digit_valid;
    assign key_held    = r_key_held;

endmodule

`default_nettype wire
